// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control path:
//   - opcode / funct constants for the supported instruction subset
//   - ALU control codes driven to the datapath ALU
//   - alu_src_b and pc_src mux encodings
//   - controller state encoding and the Moore output bundle
// Ports: none (package).
// ----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP
    } state_t;

    // Outputs that depend only on the state; these are registered so the
    // datapath sees glitch-free enables.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } moore_t;

    // States that own a memory access and therefore run the wait counter.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    function automatic moore_t moore_decode(state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_read  = 1'b1;
                m.alu_src_b = SRCB_FOUR;
            end
            // Branch target is computed speculatively while decoding.
            S_DECODE: m.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                m.mem_read = 1'b1;
                m.iord     = 1'b1;
            end
            S_MEMWB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                m.mem_write = 1'b1;
                m.iord      = 1'b1;
            end
            S_EXEC: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_REGB;
            end
            S_ALUWB: begin
                m.reg_write = 1'b1;
                m.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                m.alu_src_a     = 1'b1;
                m.alu_src_b     = SRCB_REGB;
                m.pc_write_cond = 1'b1;
                m.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                m.pc_write = 1'b1;
                m.pc_src   = PCSRC_JUMP;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the multicycle controller and the datapath/memory.
//   master : controller side (consumes opcode/funct/mem_ready, drives controls)
//   slave  : datapath side
// Signals:
//   opcode[5:0], funct[5:0]  IR fields from the datapath
//   mem_ready                memory completes current access
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//   pc_src[1:0], alu_control[2:0]   datapath controls
//   illegal_op, mem_err      status pulses
// ----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_control, illegal_op, mem_err
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_control, illegal_op, mem_err
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// ----------------------------------------------------------------------------
// mips_alu_decoder
// Combinational R-type funct -> ALU control mapping. Unknown funct codes map
// to AND (000) so the ALU is never left without a defined operation.
// Ports:
//   funct[5:0]        in   IR[5:0]
//   alu_control[2:0]  out  ALU operation code
// ----------------------------------------------------------------------------
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_AND;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multicycle MIPS controller: sequences a shared PC/IR/ALU/memory datapath
// through fetch/decode/execute/memory/writeback for R-type, lw, sw, beq and
// (optionally) j. Memory accesses use a req/ready handshake with a bounded
// wait; a timeout pulses mem_err and returns to FETCH.
// Configuration macro: MIPS_JUMP_EN (enables the j instruction; otherwise
// opcode 000010 is reported as illegal).
// Parameters:
//   MEM_TIMEOUT  max wait cycles per memory access (0 disables the timeout)
//   TO_W         wait counter width, must hold MEM_TIMEOUT
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    mips_multicycle_ctrl_if.master (IR fields, mem_ready, controls)
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mips_multicycle_ctrl_if.master    bus
);

    state_t          state;
    state_t          next_state;
    moore_t          mo_q;
    logic [TO_W-1:0] wait_cnt;
    logic            timeout;
    logic            op_legal;
    logic            enter_mem;
    logic [2:0]      exec_alu;

    mips_alu_decoder u_alu_dec (
        .funct       (bus.funct),
        .alu_control (exec_alu)
    );

    // A ready on the limit cycle still counts as completion, so the timeout
    // only fires when ready is low.
    assign timeout = (MEM_TIMEOUT != 0) && is_mem_state(state) && !bus.mem_ready
                     && (wait_cnt == TO_W'(MEM_TIMEOUT));

    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
`ifdef MIPS_JUMP_EN
            OP_J: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_FETCH;
            S_FETCH: next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
`ifdef MIPS_JUMP_EN
                    OP_J:         next_state = S_JUMP;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready)  next_state = S_MEMWB;
                else if (timeout)   next_state = S_FETCH;
                else                next_state = S_MEMRD;
            end
            S_MEMWR: begin
                if (bus.mem_ready || timeout) next_state = S_FETCH;
                else                          next_state = S_MEMWR;
            end
            S_MEMWB:  next_state = S_FETCH;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    // A FETCH timeout loops FETCH->FETCH, which must still count as a fresh
    // entry so the retried access gets its full wait budget.
    assign enter_mem = is_mem_state(next_state) && ((next_state != state) || timeout);

    // Moore outputs are registered from the next state, so they line up with
    // the state register and clear together with it on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mo_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            mo_q  <= moore_decode(next_state);
            if (enter_mem) begin
                wait_cnt <= '0;
            end else if (is_mem_state(state) && !bus.mem_ready) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + TO_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        bus.alu_control = ALU_AND;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: bus.alu_control = ALU_ADD;
            S_EXEC:                      bus.alu_control = exec_alu;
            S_BRANCH:                    bus.alu_control = ALU_SUB;
            default:                     bus.alu_control = ALU_AND;
        endcase
    end

    // IR and PC+4 are only captured in the cycle the fetch actually completes.
    assign bus.ir_write      = (state == S_FETCH) && bus.mem_ready;
    assign bus.pc_write      = mo_q.pc_write || ((state == S_FETCH) && bus.mem_ready);
    assign bus.illegal_op    = (state == S_DECODE) && !op_legal;
    assign bus.mem_err       = timeout;
    assign bus.pc_write_cond = mo_q.pc_write_cond;
    assign bus.iord          = mo_q.iord;
    assign bus.mem_read      = mo_q.mem_read;
    assign bus.mem_write     = mo_q.mem_write;
    assign bus.reg_dst       = mo_q.reg_dst;
    assign bus.mem_to_reg    = mo_q.mem_to_reg;
    assign bus.reg_write     = mo_q.reg_write;
    assign bus.alu_src_a     = mo_q.alu_src_a;
    assign bus.alu_src_b     = mo_q.alu_src_b;
    assign bus.pc_src        = mo_q.pc_src;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Self-checking bench for mips_multicycle_ctrl (MEM_TIMEOUT = 4).
// Honours MIPS_JUMP_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal_op;
        logic       mem_err;
    } outs_t;

    typedef struct packed {
        logic        rdy;
        logic [5:0]  opc;
        logic [5:0]  fn;
        outs_t       exp;
        logic [63:0] tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[$];
    vec_t plan[$];
    outs_t act;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign act = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                  bus.alu_control, bus.illegal_op, bus.mem_err};

    // Expected control words per phase of an instruction
    function automatic outs_t fetchO(logic rdy);
        outs_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_control = 3'b010;
        o.ir_write = rdy;  o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t decodeO(logic ill);
        outs_t o = '0;
        o.alu_src_b = 2'b11; o.alu_control = 3'b010; o.illegal_op = ill;
        return o;
    endfunction
    function automatic outs_t memadrO();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = 3'b010;
        return o;
    endfunction
    function automatic outs_t memrdO();
        outs_t o = '0;
        o.mem_read = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic outs_t memwrO();
        outs_t o = '0;
        o.mem_write = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic outs_t memwbO();
        outs_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        return o;
    endfunction
    function automatic outs_t execO(logic [2:0] alu);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_control = alu;
        return o;
    endfunction
    function automatic outs_t aluwbO();
        outs_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 1'b1;
        return o;
    endfunction
    function automatic outs_t branchO();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_control = 3'b110;
        o.pc_write_cond = 1'b1; o.pc_src = 2'b01;
        return o;
    endfunction
    function automatic outs_t jumpO();
        outs_t o = '0;
        o.pc_write = 1'b1; o.pc_src = 2'b10;
        return o;
    endfunction
    function automatic outs_t withErr(outs_t i);
        outs_t o = i;
        o.mem_err = 1'b1;
        return o;
    endfunction

    function automatic logic [2:0] aluFor(logic [5:0] fn);
        case (fn)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic vec_t mk(logic rdy, logic [5:0] opc, logic [5:0] fn,
                                outs_t e, logic [63:0] tag);
        vec_t v;
        v.rdy = rdy; v.opc = opc; v.fn = fn; v.exp = e; v.tag = tag;
        return v;
    endfunction

    function automatic outs_t accO(int kind, logic rdy);
        if (kind == 0) return fetchO(rdy);
        if (kind == 1) return memrdO();
        return memwrO();
    endfunction

    // One memory access with 'waits' not-ready cycles; returns 0 on timeout.
    function automatic bit planAccess(int kind, int waits, logic [5:0] opc, logic [5:0] fn);
        for (int i = 0; i <= TO; i++) begin
            if (i < waits) begin
                if (i == TO) begin
                    plan.push_back(mk(1'b0, opc, fn, withErr(accO(kind, 1'b0)), "TIMEOUT"));
                    return 1'b0;
                end
                plan.push_back(mk(1'b0, opc, fn, accO(kind, 1'b0), "MEMWAIT"));
            end else begin
                plan.push_back(mk(1'b1, opc, fn, accO(kind, 1'b1), "MEMDONE"));
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic bit legalOpc(logic [5:0] o);
        return (o == 6'd0) || (o == 6'd2) || (o == 6'd4) || (o == 6'd35) || (o == 6'd43);
    endfunction

    // Kinds: 0 R, 1 lw, 2 sw, 3 beq, 4 illegal, 5 j
    function automatic void planInstr(int kind, int fw, int mw);
        logic [5:0] opc;
        logic [5:0] fn;
        logic [5:0] fns[6];
        int w;
        fns[0] = 6'd32; fns[1] = 6'd34; fns[2] = 6'd36; fns[3] = 6'd37; fns[4] = 6'd42;
        fns[5] = 6'd0;
        fn = 6'($urandom_range(0, 63));
        case (kind)
            0: begin
                opc = 6'd0;
                fn = fns[$urandom_range(0, 5)];
                if (fn == 6'd0) fn = 6'd63;
            end
            1: opc = 6'd35;
            2: opc = 6'd43;
            3: opc = 6'd4;
            5: opc = 6'd2;
            default: begin
                opc = 6'($urandom_range(0, 63));
                while (legalOpc(opc)) opc = 6'($urandom_range(0, 63));
            end
        endcase
        w = fw;
        while (!planAccess(0, w, opc, fn)) w = $urandom_range(0, TO);
        case (kind)
            0: begin
                plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b0), "DECODE"));
                plan.push_back(mk(1'($urandom), opc, fn, execO(aluFor(fn)), "EXEC"));
                plan.push_back(mk(1'($urandom), opc, fn, aluwbO(), "ALUWB"));
            end
            1: begin
                plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b0), "DECODE"));
                plan.push_back(mk(1'($urandom), opc, fn, memadrO(), "MEMADR"));
                if (planAccess(1, mw, opc, fn))
                    plan.push_back(mk(1'($urandom), opc, fn, memwbO(), "MEMWB"));
            end
            2: begin
                plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b0), "DECODE"));
                plan.push_back(mk(1'($urandom), opc, fn, memadrO(), "MEMADR"));
                void'(planAccess(2, mw, opc, fn));
            end
            3: begin
                plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b0), "DECODE"));
                plan.push_back(mk(1'($urandom), opc, fn, branchO(), "BRANCH"));
            end
            5: begin
`ifdef MIPS_JUMP_EN
                plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b0), "DECODE"));
                plan.push_back(mk(1'($urandom), opc, fn, jumpO(), "JUMP"));
`else
                plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b1), "DEC_ILL"));
`endif
            end
            default: plan.push_back(mk(1'($urandom), opc, fn, decodeO(1'b1), "DEC_ILL"));
        endcase
    endfunction

    task automatic checkOutput(input logic [63:0] tag, input outs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %0s at %0t: got %b expected %b", tag, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        bus.mem_ready = v.rdy;
        bus.opcode    = v.opc;
        bus.funct     = v.fn;
        #3;
        checkOutput(v.tag, v.exp);
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;

        @(posedge clk);
        #1 checkOutput("RESET", '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #2 checkOutput("IDLE", '0);

        // Directed program: R add, lw with 3 waits, sw, beq, illegal, j
        tbl.push_back(mk(1, 6'd0, 6'd32, fetchO(1), "R_FETCH"));
        tbl.push_back(mk(1, 6'd0, 6'd32, decodeO(0), "R_DEC"));
        tbl.push_back(mk(1, 6'd0, 6'd32, execO(3'b010), "R_EXEC"));
        tbl.push_back(mk(1, 6'd0, 6'd32, aluwbO(), "R_WB"));
        tbl.push_back(mk(1, 6'd35, 6'd0, fetchO(1), "LW_FET"));
        tbl.push_back(mk(0, 6'd35, 6'd0, decodeO(0), "LW_DEC"));
        tbl.push_back(mk(1, 6'd35, 6'd0, memadrO(), "LW_ADR"));
        tbl.push_back(mk(0, 6'd35, 6'd0, memrdO(), "LW_RD0"));
        tbl.push_back(mk(0, 6'd35, 6'd0, memrdO(), "LW_RD1"));
        tbl.push_back(mk(0, 6'd35, 6'd0, memrdO(), "LW_RD2"));
        tbl.push_back(mk(1, 6'd35, 6'd0, memrdO(), "LW_RD3"));
        tbl.push_back(mk(1, 6'd35, 6'd0, memwbO(), "LW_WB"));
        tbl.push_back(mk(1, 6'd43, 6'd0, fetchO(1), "SW_FET"));
        tbl.push_back(mk(1, 6'd43, 6'd0, decodeO(0), "SW_DEC"));
        tbl.push_back(mk(0, 6'd43, 6'd0, memadrO(), "SW_ADR"));
        tbl.push_back(mk(1, 6'd43, 6'd0, memwrO(), "SW_WR"));
        tbl.push_back(mk(1, 6'd4, 6'd0, fetchO(1), "BQ_FET"));
        tbl.push_back(mk(1, 6'd4, 6'd0, decodeO(0), "BQ_DEC"));
        tbl.push_back(mk(1, 6'd4, 6'd0, branchO(), "BQ_BR"));
        tbl.push_back(mk(1, 6'd63, 6'd0, fetchO(1), "IL_FET"));
        tbl.push_back(mk(1, 6'd63, 6'd0, decodeO(1), "IL_DEC"));
        tbl.push_back(mk(1, 6'd2, 6'd0, fetchO(1), "J_FET"));
`ifdef MIPS_JUMP_EN
        tbl.push_back(mk(1, 6'd2, 6'd0, decodeO(0), "J_DEC"));
        tbl.push_back(mk(1, 6'd2, 6'd0, jumpO(), "J_JUMP"));
`else
        tbl.push_back(mk(1, 6'd2, 6'd0, decodeO(1), "J_DECIL"));
`endif
        tbl.push_back(mk(1, 6'd0, 6'd34, fetchO(1), "S_FETCH"));
        tbl.push_back(mk(1, 6'd0, 6'd34, decodeO(0), "S_DEC"));
        tbl.push_back(mk(1, 6'd0, 6'd34, execO(3'b110), "S_EXEC"));
        tbl.push_back(mk(1, 6'd0, 6'd34, aluwbO(), "S_WB"));
        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

        // Fetch timeout: error after 4 waits, refetch restarts the count
        for (int i = 0; i < TO; i++) applyStimulus(mk(0, 6'd0, 6'd37, fetchO(0), "TO_WAIT"));
        applyStimulus(mk(0, 6'd0, 6'd37, withErr(fetchO(0)), "TO_ERR"));
        for (int i = 0; i < TO; i++) applyStimulus(mk(0, 6'd0, 6'd37, fetchO(0), "TO_RWAIT"));
        applyStimulus(mk(0, 6'd0, 6'd37, withErr(fetchO(0)), "TO_ERR2"));
        applyStimulus(mk(1, 6'd0, 6'd37, fetchO(1), "TO_DONE"));
        applyStimulus(mk(1, 6'd0, 6'd37, decodeO(0), "TO_DEC"));
        applyStimulus(mk(1, 6'd0, 6'd37, execO(3'b001), "TO_EXEC"));
        applyStimulus(mk(1, 6'd0, 6'd37, aluwbO(), "TO_WB"));

        // Ready on the limit cycle completes normally; memory timeouts
        plan.delete();
        planInstr(3, TO, 0);
        planInstr(1, 0, TO + 1);
        planInstr(2, 0, TO + 2);
        planInstr(1, 0, TO);
        foreach (plan[i]) applyStimulus(plan[i]);

        // Randomised instruction stream against the phase model
        repeat (250) begin
            plan.delete();
            planInstr($urandom_range(0, 5), $urandom_range(0, TO + 2), $urandom_range(0, TO + 2));
            foreach (plan[i]) applyStimulus(plan[i]);
        end

        // Reset asserted in the middle of a store
        applyStimulus(mk(1, 6'd43, 6'd0, fetchO(1), "RS_FET"));
        applyStimulus(mk(1, 6'd43, 6'd0, decodeO(0), "RS_DEC"));
        applyStimulus(mk(1, 6'd43, 6'd0, memadrO(), "RS_ADR"));
        applyStimulus(mk(0, 6'd43, 6'd0, memwrO(), "RS_WR"));
        #1 rst_n = 1'b0;
        #1 checkOutput("RS_DROP", '0);
        @(posedge clk);
        #1 checkOutput("RS_HOLD", '0);
        #1 rst_n = 1'b1;
        #2 checkOutput("RS_IDLE", '0);
        applyStimulus(mk(1, 6'd0, 6'd32, fetchO(1), "RS_FET2"));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
